clause_loader: RTL and testbench

CLAUSE_LOADER -- requirements
Module: clause_loader

---
 rtl/clause_loader_pkg.sv | 22 ++
 rtl/clause_loader_lit_decode.sv | 25 ++
 rtl/clause_loader.sv | 94 +++++++++
 tb/tb_clause_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clause_loader_pkg.sv
// Shared definitions for the CNF clause loader and the solver that consumes its masks.
package clause_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  // A clause holds at most this many literals.
  localparam int unsigned MAX_LITS = 3;

  // Bits needed to index n items (at least 1).
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/clause_loader_lit_decode.sv
// One-hot decoder for a literal's variable index, with a flag for indices below N.
module lit_decode
  import clause_loader_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned W = idx_width(N)
) (
  input  logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         in_range
);

  // Set the bit selected by idx; an index with no matching bit is out of range.
  always_comb begin
    onehot   = '0;
    in_range = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx == W'(i)) begin
        onehot[i] = 1'b1;
        in_range  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clause_loader.sv
// Streams CNF literals into per-clause positive/negated variable masks for the solver.
module clause_loader
  import clause_loader_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned M = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    lit_valid,
  output logic                    lit_ready,
  input  logic [idx_width(N)-1:0] lit_var,
  input  logic                    lit_neg,
  input  logic                    lit_last,
  output logic [N*M-1:0]          pos_mask,
  output logic [N*M-1:0]          neg_mask,
  output logic                    load_done,
  output logic                    err
);

  localparam int unsigned VW = idx_width(N);
  localparam int unsigned CW = idx_width(M);

  state_t        state;
  logic [CW-1:0] clause_idx;
  logic [1:0]    lit_cnt;
  logic [N-1:0]  onehot;
  logic          in_range;

  lit_decode #(.N(N), .W(VW)) u_lit_decode (
    .idx      (lit_var),
    .onehot   (onehot),
    .in_range (in_range)
  );

  // Accept literals only while loading and not being restarted this cycle.
  always_comb begin
    lit_ready = (state == LOAD) && !start;
  end

  // Load FSM with registered masks and status; start overrides every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pos_mask   <= '0;
      neg_mask   <= '0;
      load_done  <= 1'b0;
      err        <= 1'b0;
      clause_idx <= '0;
      lit_cnt    <= '0;
    end else if (start) begin
      state      <= LOAD;
      pos_mask   <= '0;
      neg_mask   <= '0;
      load_done  <= 1'b0;
      err        <= 1'b0;
      clause_idx <= '0;
      lit_cnt    <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (lit_valid) begin
            if (!in_range || lit_cnt == 2'(MAX_LITS)) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              if (lit_neg)
                neg_mask[clause_idx*N +: N] <= neg_mask[clause_idx*N +: N] | onehot;
              else
                pos_mask[clause_idx*N +: N] <= pos_mask[clause_idx*N +: N] | onehot;
              if (lit_last) begin
                lit_cnt <= '0;
                // load_done rises together with DONE so it is visible the cycle after the last literal.
                if (clause_idx == CW'(M - 1)) begin
                  state     <= DONE;
                  load_done <= 1'b1;
                end else begin
                  clause_idx <= clause_idx + 1'b1;
                end
              end else begin
                lit_cnt <= lit_cnt + 1'b1;
              end
            end
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clause_loader.sv
// Randomized and directed bench for clause_loader against a literal-list reference model.
module tb_clause_loader;

  localparam int NA = 4;
  localparam int MA = 4;
  localparam int NB = 5;
  localparam int MB = 2;

  typedef struct {
    int v;
    bit neg;
    bit last;
  } lit_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start, lit_valid, lit_ready, lit_neg, lit_last, load_done, err;
  logic [1:0]  lit_var;
  logic [15:0] pos_mask, neg_mask;

  logic        b_start, b_lit_valid, b_lit_ready, b_lit_neg, b_lit_last, b_load_done, b_err;
  logic [2:0]  b_lit_var;
  logic [9:0]  b_pos_mask, b_neg_mask;

  int n_checks = 0;
  int n_errors = 0;

  clause_loader #(.N(NA), .M(MA)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .lit_valid (lit_valid),
    .lit_ready (lit_ready),
    .lit_var   (lit_var),
    .lit_neg   (lit_neg),
    .lit_last  (lit_last),
    .pos_mask  (pos_mask),
    .neg_mask  (neg_mask),
    .load_done (load_done),
    .err       (err)
  );

  clause_loader #(.N(NB), .M(MB)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .start     (b_start),
    .lit_valid (b_lit_valid),
    .lit_ready (b_lit_ready),
    .lit_var   (b_lit_var),
    .lit_neg   (b_lit_neg),
    .lit_last  (b_lit_last),
    .pos_mask  (b_pos_mask),
    .neg_mask  (b_neg_mask),
    .load_done (b_load_done),
    .err       (b_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic lit_t mk(input int v, input bit neg, input bit last);
    lit_t l;
    l.v = v;
    l.neg = neg;
    l.last = last;
    return l;
  endfunction

  // Reference: walk the literal list; a clause closes on last, at most 3 literals each,
  // variables must be below n; the load ends on the m-th closed clause or on the first bad literal.
  function automatic void model(input lit_t q[$], input int n, input int m,
                                output logic [63:0] p, output logic [63:0] ng,
                                output bit done, output bit er, output int acc);
    int clause;
    int cnt;
    clause = 0; cnt = 0;
    p = '0; ng = '0; done = 0; er = 0; acc = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (done || er) break;
      acc++;
      if (q[i].v >= n || cnt == 3) begin
        er = 1;
        break;
      end
      if (q[i].neg) ng[clause*n + q[i].v] = 1'b1;
      else          p[clause*n + q[i].v]  = 1'b1;
      cnt++;
      if (q[i].last) begin
        cnt = 0;
        clause++;
        if (clause == m) done = 1;
      end
    end
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: valid every cycle, 1: valid every other cycle, 2: random valid.
  task automatic run_a(input lit_t q[$], input int mode, input bit do_start, input string tag);
    int idx;
    int cyc;
    int early;
    logic [63:0] ep, en;
    bit ed, ee;
    int ea;
    idx = 0; cyc = 0; early = 0;
    model(q, NA, MA, ep, en, ed, ee, ea);
    if (do_start) pulse_start();
    while (idx < q.size() && cyc < 400) begin
      lit_var  = 2'(q[idx].v);
      lit_neg  = q[idx].neg;
      lit_last = q[idx].last;
      case (mode)
        0:       lit_valid = 1'b1;
        1:       lit_valid = (cyc % 2 == 0);
        default: lit_valid = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (!lit_ready) break;
      if (load_done) early++;
      if (lit_valid) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    lit_valid = 1'b0;
    check({tag, "_bounded"}, 64'(cyc < 400), 64'd1);
    check({tag, "_acc"}, 64'(idx), 64'(ea));
    check({tag, "_pos"}, 64'(pos_mask), ep);
    check({tag, "_neg"}, 64'(neg_mask), en);
    check({tag, "_done"}, 64'(load_done), 64'(ed));
    check({tag, "_err"}, 64'(err), 64'(ee));
    check({tag, "_ready"}, 64'(lit_ready), 64'(!(ed || ee)));
    check({tag, "_early_done"}, 64'(early), 64'd0);
  endtask

  task automatic run_b(input lit_t q[$], input string tag);
    logic [63:0] ep, en;
    bit ed, ee;
    int ea;
    model(q, NB, MB, ep, en, ed, ee, ea);
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      b_lit_var   = 3'(q[i].v);
      b_lit_neg   = q[i].neg;
      b_lit_last  = q[i].last;
      b_lit_valid = 1'b1;
      @(posedge clk); #1;
    end
    b_lit_valid = 1'b0;
    check({tag, "_pos"}, 64'(b_pos_mask), ep);
    check({tag, "_neg"}, 64'(b_neg_mask), en);
    check({tag, "_done"}, 64'(b_load_done), 64'(ed));
    check({tag, "_err"}, 64'(b_err), 64'(ee));
  endtask

  initial begin
    lit_t stream[$];
    lit_t q[$];
    int sz;

    reset = 1'b0;
    start = 1'b0; lit_valid = 1'b0; lit_var = '0; lit_neg = 1'b0; lit_last = 1'b0;
    b_start = 1'b0; b_lit_valid = 1'b0; b_lit_var = '0; b_lit_neg = 1'b0; b_lit_last = 1'b0;

    // Reset state
    #1;
    check("rst_pos", 64'(pos_mask), 64'd0);
    check("rst_neg", 64'(neg_mask), 64'd0);
    check("rst_done", 64'(load_done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_ready", 64'(lit_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // First edge after reset without start stays idle and ignores literals
    lit_valid = 1'b1; lit_var = 2'd2; lit_neg = 1'b0; lit_last = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 64'(lit_ready), 64'd0);
    check("idle_pos", 64'(pos_mask), 64'd0);
    lit_valid = 1'b0;

    // Cyclic stream without stalls
    stream = {mk(0,0,0), mk(3,1,1), mk(1,0,0), mk(0,1,1),
              mk(2,0,0), mk(1,1,1), mk(3,0,0), mk(2,1,1)};
    run_a(stream, 0, 1'b1, "cyc");
    check("cyc_pos_const", 64'(pos_mask), 64'h8421);
    check("cyc_neg_const", 64'(neg_mask), 64'h4218);

    // Literals are ignored once done
    lit_valid = 1'b1; lit_var = 2'd1; lit_neg = 1'b1; lit_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lit_valid = 1'b0;
    check("done_hold_pos", 64'(pos_mask), 64'h8421);
    check("done_hold_neg", 64'(neg_mask), 64'h4218);
    check("done_hold_ready", 64'(lit_ready), 64'd0);

    // Same stream with toggled valid
    run_a(stream, 1, 1'b1, "toggle");

    // Both polarities of one variable in a clause
    q = {mk(1,0,0), mk(1,1,1), mk(0,0,1), mk(2,1,1), mk(3,0,1)};
    run_a(q, 0, 1'b1, "both");
    check("both_pos_b1", 64'(pos_mask[1]), 64'd1);
    check("both_neg_b1", 64'(neg_mask[1]), 64'd1);

    // Abort after three literals; the literal offered with start is refused
    q = {mk(2,0,0), mk(0,1,1), mk(3,0,0)};
    run_a(q, 0, 1'b1, "abort_pre");
    start = 1'b1; lit_valid = 1'b1; lit_var = 2'd1; lit_neg = 1'b0; lit_last = 1'b1;
    #1;
    check("abort_ready", 64'(lit_ready), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; lit_valid = 1'b0;
    run_a(stream, 0, 1'b0, "abort");

    // Fourth literal in a clause
    q = {mk(0,0,0), mk(1,0,0), mk(2,0,0), mk(3,0,1)};
    run_a(q, 0, 1'b1, "ovf");
    check("ovf_bit3", 64'(pos_mask[3]), 64'd0);

    // Asynchronous reset out of the error state
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("arst_err_err", 64'(err), 64'd0);
    check("arst_err_pos", 64'(pos_mask), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset mid-load
    q = {mk(0,0,0), mk(3,1,1), mk(1,0,0)};
    run_a(q, 0, 1'b1, "mid");
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("arst_mid_pos", 64'(pos_mask), 64'd0);
    check("arst_mid_neg", 64'(neg_mask), 64'd0);
    check("arst_mid_done", 64'(load_done), 64'd0);
    check("arst_mid_ready", 64'(lit_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Random loads
    for (int t = 0; t < 30; t++) begin
      q = {};
      for (int c = 0; c < MA; c++) begin
        sz = ($urandom_range(0, 9) == 0) ? 4 : int'($urandom_range(1, 3));
        for (int k = 0; k < sz; k++)
          q.push_back(mk(int'($urandom_range(0, NA-1)), bit'($urandom_range(0, 1)), k == sz-1));
      end
      run_a(q, int'($urandom_range(0, 2)), 1'b1, $sformatf("rnd%0d", t));
    end

    // Non-power-of-two variable count
    q = {mk(4,0,1), mk(0,0,0), mk(4,1,1)};
    run_b(q, "n5_ok");
    q = {mk(2,0,0), mk(6,0,1), mk(1,0,1)};
    run_b(q, "n5_range");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
